rc4_task_sequencer: RTL

//  Top-level controller for the RC4 key-search datapath. For each candidate key it runs

---
 rtl/rc4_task_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/rc4_task_sequencer.sv
// RC4 key-search task sequencer.
// Walks every candidate key through S-init, KSA swap and decrypt/check, one
// task at a time. It grants the shared single-port S memory to whichever task
// is active. A per-task watchdog aborts the search if any one task hangs.
module rc4_task_sequencer #(
  parameter logic [23:0] KEY_MAX = 24'h3FFFFF,
  parameter logic [15:0] TIMEOUT = 16'd4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        go_i,
  input  logic        init_finish_i,
  input  logic        swap_finish_i,
  input  logic        decr_finish_i,
  input  logic        decr_match_i,
  input  logic [7:0]  init_addr_i,
  input  logic [7:0]  init_wdata_i,
  input  logic        init_we_i,
  input  logic [7:0]  swap_addr_i,
  input  logic [7:0]  swap_wdata_i,
  input  logic        swap_we_i,
  input  logic [7:0]  decr_addr_i,
  input  logic [7:0]  decr_wdata_i,
  input  logic        decr_we_i,
  output logic        init_start_o,
  output logic        swap_start_o,
  output logic        decr_start_o,
  output logic [23:0] skey_o,
  output logic [7:0]  mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  output logic        mem_we_o,
  output logic        busy_o,
  output logic        found_o,
  output logic        fail_o,
  output logic        timeout_err_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT_GO, S_INIT_WAIT, S_SWAP_GO, S_SWAP_WAIT,
    S_DECR_GO, S_DECR_WAIT, S_NEXT_KEY, S_FOUND, S_FAIL
  } state_e;

  // Last watchdog count a task may reach before it is declared hung.
  localparam logic [15:0] WD_LAST = TIMEOUT - 16'd1;

  state_e      state_q, state_d;
  logic [23:0] skey_q, skey_d;
  logic [15:0] wd_q, wd_d;
  logic        init_start_q, init_start_d;
  logic        swap_start_q, swap_start_d;
  logic        decr_start_q, decr_start_d;
  logic        busy_q, busy_d;
  logic        found_q, found_d;
  logic        fail_q, fail_d;
  logic        timeout_err_q, timeout_err_d;
  logic        go_accept;
  logic        wd_expired;

  // State and datapath registers; reset abandons any search immediately.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      skey_q        <= '0;
      wd_q          <= '0;
      init_start_q  <= 1'b0;
      swap_start_q  <= 1'b0;
      decr_start_q  <= 1'b0;
      busy_q        <= 1'b0;
      found_q       <= 1'b0;
      fail_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      skey_q        <= skey_d;
      wd_q          <= wd_d;
      init_start_q  <= init_start_d;
      swap_start_q  <= swap_start_d;
      decr_start_q  <= decr_start_d;
      busy_q        <= busy_d;
      found_q       <= found_d;
      fail_q        <= fail_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic; only the awaited finish pulse is ever looked at.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    go_accept  = 1'b0;
    wd_expired = 1'b0;
    unique case (state_q)
      S_IDLE, S_FOUND, S_FAIL: begin
        if (go_i) begin
          state_d   = S_INIT_GO;
          go_accept = 1'b1;
        end
      end
      S_INIT_GO: state_d = S_INIT_WAIT;
      S_INIT_WAIT: begin
        if (init_finish_i) begin
          state_d = S_SWAP_GO;
        end else if (wd_q == WD_LAST) begin
          state_d    = S_FAIL;
          wd_expired = 1'b1;
        end
      end
      S_SWAP_GO: state_d = S_SWAP_WAIT;
      S_SWAP_WAIT: begin
        if (swap_finish_i) begin
          state_d = S_DECR_GO;
        end else if (wd_q == WD_LAST) begin
          state_d    = S_FAIL;
          wd_expired = 1'b1;
        end
      end
      S_DECR_GO: state_d = S_DECR_WAIT;
      S_DECR_WAIT: begin
        if (decr_finish_i) begin
          if (decr_match_i)          state_d = S_FOUND;
          else if (skey_q == KEY_MAX) state_d = S_FAIL;
          else                        state_d = S_NEXT_KEY;
        end else if (wd_q == WD_LAST) begin
          state_d    = S_FAIL;
          wd_expired = 1'b1;
        end
      end
      S_NEXT_KEY: state_d = S_INIT_GO;
      default:    state_d = S_IDLE;
    endcase
  end

  // Registered-output next values, key/watchdog update and memory grant mux.
  always_comb begin
    skey_d        = skey_q;
    wd_d          = wd_q;
    timeout_err_d = timeout_err_q;
    mem_addr_o    = 8'h00;
    mem_wdata_o   = 8'h00;
    mem_we_o      = 1'b0;

    if (go_accept) begin
      skey_d        = '0;
      timeout_err_d = 1'b0;
    end
    if (wd_expired) timeout_err_d = 1'b1;
    if (state_q == S_NEXT_KEY) skey_d = skey_q + 24'd1;

    unique case (state_q)
      S_INIT_GO, S_SWAP_GO, S_DECR_GO:       wd_d = '0;
      S_INIT_WAIT, S_SWAP_WAIT, S_DECR_WAIT: wd_d = wd_q + 16'd1;
      default:                               wd_d = wd_q;
    endcase

    init_start_d = (state_d == S_INIT_GO);
    swap_start_d = (state_d == S_SWAP_GO);
    decr_start_d = (state_d == S_DECR_GO);
    found_d      = (state_d == S_FOUND);
    fail_d       = (state_d == S_FAIL);
    busy_d       = !(state_d inside {S_IDLE, S_FOUND, S_FAIL});

    unique case (state_q)
      S_INIT_GO, S_INIT_WAIT: begin
        mem_addr_o  = init_addr_i;
        mem_wdata_o = init_wdata_i;
        mem_we_o    = init_we_i;
      end
      S_SWAP_GO, S_SWAP_WAIT: begin
        mem_addr_o  = swap_addr_i;
        mem_wdata_o = swap_wdata_i;
        mem_we_o    = swap_we_i;
      end
      S_DECR_GO, S_DECR_WAIT: begin
        mem_addr_o  = decr_addr_i;
        mem_wdata_o = decr_wdata_i;
        mem_we_o    = decr_we_i;
      end
      default: ;
    endcase
  end

  assign init_start_o  = init_start_q;
  assign swap_start_o  = swap_start_q;
  assign decr_start_o  = decr_start_q;
  assign skey_o        = skey_q;
  assign busy_o        = busy_q;
  assign found_o       = found_q;
  assign fail_o        = fail_q;
  assign timeout_err_o = timeout_err_q;

endmodule
